// File: rtl/memory_port_arbiter.sv
// Shares one single-port synchronous SRAM between a read-only fetch port and a read/write data port.
// Data has priority; a saturating streak counter lets fetch in after STARVE_LIMIT consecutive data wins.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_WIDTH-1:0]   i_rsp_data,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic                    d_req_write,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
  output logic                    d_rsp_valid,
  input  logic                    d_rsp_ready,
  output logic [DATA_WIDTH-1:0]   d_rsp_data,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t     state, state_nxt;
  logic       owner;  // 1 = data port owns the outstanding read
  logic [3:0] streak;
  logic       grant_i, grant_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? LIMIT : v + 4'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (d_req_valid && !(i_req_valid && streak == LIMIT)) grant_d = 1'b1;
          else if (i_req_valid)                                  grant_i = 1'b1;
        end
        if (grant_d) begin
          mem_en    = 1'b1;
          mem_we    = d_req_write;
          mem_be    = d_req_write ? d_req_wstrb : '1;
          mem_addr  = d_req_addr;
          mem_wdata = d_req_wdata;
          if (!d_req_write) state_nxt = READ;
        end else if (grant_i) begin
          mem_en    = 1'b1;
          mem_be    = '1;
          mem_addr  = i_req_addr;
          state_nxt = READ;
        end
      end
      READ:    state_nxt = RESP;
      RESP:    if (owner ? d_rsp_ready : i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    i_req_ready = grant_i;
    d_req_ready = grant_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      streak      <= 4'd0;
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (grant_i || !i_req_valid) streak <= 4'd0;
        else if (grant_d)            streak <= sat_inc(streak);
        if (grant_i)                       owner <= 1'b0;
        else if (grant_d && !d_req_write)  owner <= 1'b1;
      end
      // SRAM data is valid the cycle after the strobe; park it in the owner's register
      if (state == READ) begin
        if (owner) begin
          d_rsp_valid <= 1'b1;
          d_rsp_data  <= mem_rdata;
        end else begin
          i_rsp_valid <= 1'b1;
          i_rsp_data  <= mem_rdata;
        end
      end
      if (state == RESP) begin
        if (i_rsp_valid && i_rsp_ready) i_rsp_valid <= 1'b0;
        if (d_rsp_valid && d_rsp_ready) d_rsp_valid <= 1'b0;
      end
    end
  end

endmodule
